key_load_ctrl: RTL and testbench
================================

KEY_LOAD_CTRL -- requirements
Module: key_load_ctrl

Interface
REQ-001 The block SHALL have parameter KEY_W, default 32, giving the key width in bits driven into the locked netlist.
REQ-002 The block SHALL have parameter MAX_FAIL, default 3, giving the number of consecutive failed frames that causes lockout.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port kin_valid, input, 1 bit: serial key bit offered.
REQ-006 The block SHALL have port kin_bit, input, 1 bit: serial key data, MSB first.
REQ-007 The block SHALL have port kin_last, input, 1 bit: marks the final bit of a frame.
REQ-008 The block SHALL have port kin_ready, output, 1 bit: block accepts a bit this cycle.
REQ-009 The block SHALL have port key_out, output, KEY_W bits: key applied to the key inputs of the locked netlist.
REQ-010 The block SHALL have port key_valid, output, 1 bit: key_out holds a verified key.
REQ-011 The block SHALL have port load_err, output, 1 bit: one-cycle pulse when a frame fails.
REQ-012 The block SHALL have port lockout, output, 1 bit: the block is permanently disabled until reset.

Function
REQ-013 A bit SHALL transfer on any rising edge where kin_valid and kin_ready are both 1; no other cycle shifts data.
REQ-014 The FSM SHALL use exactly five states: IDLE, SHIFT, CHECK, DONE and LOCKOUT.
REQ-015 kin_ready SHALL be 1 in IDLE, SHIFT and DONE, and 0 in CHECK and LOCKOUT.
REQ-016 A transfer in IDLE or DONE SHALL start a new frame: clear the bit counter, shift the bit in, move to SHIFT and drop key_valid on the next cycle.
REQ-017 In DONE, key_out SHALL keep the previous verified key while a reload is in progress.
REQ-018 Transferred bits SHALL shift into a KEY_W-bit shadow register, MSB first; the frame length is FL (see REQ-029).
REQ-019 The block SHALL enter CHECK after the transfer carrying kin_last, or after the FL-th transfer, whichever occurs first.
REQ-020 CHECK SHALL last exactly one cycle. A frame passes only if kin_last arrived on exactly the FL-th bit and the parity check (if enabled) is correct.
REQ-021 On pass: load the shadow register into key_out, set key_valid=1 on the following cycle, clear the fail counter, and go to DONE.
REQ-022 On fail: pulse load_err for one cycle, increment the saturating fail counter, and leave key_out and key_valid unchanged.
REQ-023 After a fail, the block SHALL go to IDLE, or to LOCKOUT if the counter reaches MAX_FAIL.
REQ-024 A kin_last arriving early SHALL fail the frame; any bits offered during CHECK SHALL be ignored (kin_ready=0).
REQ-025 In LOCKOUT: kin_ready=0, key_out=0, key_valid=0, lockout=1; the state SHALL be exited only by reset.
REQ-026 Latency SHALL be 2 cycles from the final-bit transfer to the key_valid rise.

Reset
REQ-027 Asserting rst_n low SHALL immediately force the following, including in the middle of a frame or in LOCKOUT: state=IDLE, shadow=0, key_out=0, key_valid=0, load_err=0, lockout=0, fail counter=0, bit counter=0.
REQ-028 kin_ready SHALL be 1 from the first clock edge after rst_n is deasserted.

Configuration
REQ-029 With macro KEY_LOAD_PARITY_EN defined: FL=KEY_W+1; the final bit is an even-parity bit over the key bits and is not stored; a parity mismatch fails the frame.
REQ-030 With KEY_LOAD_PARITY_EN undefined: FL=KEY_W; there is no parity check, and only the kin_last position is checked.

Verification (KEY_W=8, MAX_FAIL=3, parity enabled)
REQ-031 Good frame: send 8'hA5 then parity bit 0 with kin_last -> key_out=8'hA5, key_valid=1 two cycles after the last transfer, load_err stays 0.
REQ-032 Early last: assert kin_last on bit 5 -> load_err single pulse, key_valid stays 0, state returns to IDLE.
REQ-033 Three consecutive bad-parity frames -> lockout=1, kin_ready=0, key_out=0; a fourth good frame is ignored.
REQ-034 Reload in DONE with 8'h3C after 8'hA5: key_out=8'hA5 held during the shift, key_valid=0, then key_out=8'h3C and key_valid=1.
REQ-035 Assert rst_n low after 4 bits of a frame and from LOCKOUT -> all outputs take their reset values asynchronously; a subsequent good frame passes.
REQ-036 Toggle kin_valid with gaps and offer bits during CHECK -> only handshaken bits are counted; the result is identical to the gap-free frame.

Source files
------------

// File: rtl/key_load_if.sv
// Serial key-bit handshake between a key source and key_load_ctrl.
// One bit moves on every rising edge where kin_valid and kin_ready are both high.
interface key_load_if;
    logic kin_valid;
    logic kin_bit;
    logic kin_last;
    logic kin_ready;

    modport master (
        output kin_valid,
        output kin_bit,
        output kin_last,
        input  kin_ready
    );

    modport slave (
        input  kin_valid,
        input  kin_bit,
        input  kin_last,
        output kin_ready
    );
endinterface

// File: rtl/key_load_ctrl.sv
// Serial key loader for a logic-locked netlist, with lockout after repeated bad frames.
// Define KEY_LOAD_PARITY_EN to append and check an even-parity bit after each key.
module key_load_ctrl #(
    parameter int KEY_W    = 32,
    parameter int MAX_FAIL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    key_load_if.slave        kin,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             load_err,
    output logic             lockout
);

`ifdef KEY_LOAD_PARITY_EN
    localparam int FL = KEY_W + 1;
`else
    localparam int FL = KEY_W;
`endif
    localparam int CW = $clog2(FL + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        DONE,
        LOCKOUT
    } state_t;

    state_t           state;
    logic [KEY_W-1:0] shadow;
    logic [CW-1:0]    cnt;
    logic [FW-1:0]    fail_cnt;
    logic             last_ok;
    logic             rdy_q;

    logic             xfer;
    logic             start;
    logic [CW-1:0]    idx;
    logic [CW-1:0]    cnt_nx;
    logic             at_end;
    logic             store;
    logic [KEY_W-1:0] sh_nx;
    logic [FW-1:0]    fail_nx;
    logic             pass;
`ifdef KEY_LOAD_PARITY_EN
    logic             par_q;
    logic             par_nx;
`endif

    assign kin.kin_ready = rdy_q;

    always_comb begin
        xfer    = kin.kin_valid & rdy_q;
        start   = (state == IDLE) || (state == DONE);
        idx     = start ? '0 : cnt;
        cnt_nx  = idx + CW'(1);
        at_end  = (cnt_nx == CW'(FL));
        sh_nx   = {shadow[KEY_W-2:0], kin.kin_bit};
        fail_nx = (fail_cnt == FW'(MAX_FAIL)) ? fail_cnt
                                              : fail_cnt + FW'(1);
`ifdef KEY_LOAD_PARITY_EN
        // the trailing parity bit is folded into par_q but never stored
        store   = (idx < CW'(KEY_W));
        par_nx  = (start ? 1'b0 : par_q) ^ kin.kin_bit;
        pass    = last_ok & ~par_q;
`else
        store   = 1'b1;
        pass    = last_ok;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shadow    <= '0;
            cnt       <= '0;
            fail_cnt  <= '0;
            last_ok   <= 1'b0;
            rdy_q     <= 1'b0;
            key_out   <= '0;
            key_valid <= 1'b0;
            load_err  <= 1'b0;
            lockout   <= 1'b0;
`ifdef KEY_LOAD_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            load_err <= 1'b0;
            unique case (state)
                IDLE, SHIFT, DONE: begin
                    rdy_q <= 1'b1;
                    if (xfer) begin
                        cnt       <= cnt_nx;
                        key_valid <= 1'b0;
                        last_ok   <= kin.kin_last & at_end;
`ifdef KEY_LOAD_PARITY_EN
                        par_q     <= par_nx;
`endif
                        if (store) begin
                            shadow <= sh_nx;
                        end
                        if (kin.kin_last || at_end) begin
                            state <= CHECK;
                            rdy_q <= 1'b0;
                        end else begin
                            state <= SHIFT;
                        end
                    end else if (state == DONE) begin
                        key_valid <= 1'b1;
                    end
                end
                CHECK: begin
                    cnt <= '0;
                    if (pass) begin
                        key_out  <= shadow;
                        fail_cnt <= '0;
                        state    <= DONE;
                        rdy_q    <= 1'b1;
                    end else begin
                        load_err <= 1'b1;
                        fail_cnt <= fail_nx;
                        if (fail_nx == FW'(MAX_FAIL)) begin
                            state     <= LOCKOUT;
                            rdy_q     <= 1'b0;
                            lockout   <= 1'b1;
                            key_out   <= '0;
                            key_valid <= 1'b0;
                        end else begin
                            state <= IDLE;
                            rdy_q <= 1'b1;
                        end
                    end
                end
                LOCKOUT: begin
                    rdy_q     <= 1'b0;
                    lockout   <= 1'b1;
                    key_out   <= '0;
                    key_valid <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    rdy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed bench for key_load_ctrl with KEY_W=8, MAX_FAIL=3.
// Works with or without KEY_LOAD_PARITY_EN; bad frames use bad parity or an early last.
module tb_key_load_ctrl;

`ifdef KEY_LOAD_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int FL  = 9;
`else
    localparam bit PAR = 1'b0;
    localparam int FL  = 8;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] key_out;
    logic       key_valid;
    logic       load_err;
    logic       lockout;
    int         vec;
    int         errs;

    key_load_if kif ();

    key_load_ctrl #(
        .KEY_W    (8),
        .MAX_FAIL (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .kin       (kif),
        .key_out   (key_out),
        .key_valid (key_valid),
        .load_err  (load_err),
        .lockout   (lockout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic xfer_bit(input logic b, input logic l);
        int n;
        kif.kin_valid = 1'b1;
        kif.kin_bit   = b;
        kif.kin_last  = l;
        n = 0;
        while (kif.kin_ready !== 1'b1 && n < 32) begin
            @(negedge clk);
            n++;
        end
        if (kif.kin_ready !== 1'b1) begin
            vec++; errs++;
            $display("FAIL xfer_timeout: kin_ready=%b want 1", kif.kin_ready);
        end
        @(posedge clk);
        @(negedge clk);
        kif.kin_valid = 1'b0;
        kif.kin_last  = 1'b0;
    endtask

    task automatic send_key(input logic [7:0] k, input logic bad);
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(k[i], !PAR && i == 0);
        end
        if (PAR) begin
            xfer_bit(^k ^ bad, 1'b1);
        end
    endtask

    task automatic bad_frame(input logic [7:0] k);
        if (PAR) begin
            send_key(k, 1'b1);
        end else begin
            for (int i = 7; i >= 3; i--) begin
                xfer_bit(k[i], i == 3);
            end
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        kif.kin_valid = 1'b0;
        kif.kin_last  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        kif.kin_valid = 1'b0;
        kif.kin_bit   = 1'b0;
        kif.kin_last  = 1'b0;
        #1;
        vec++;
        if ({lockout, load_err, key_valid, key_out} !== 11'h0) begin
            errs++;
            $display("FAIL reset_outputs: got lk=%b err=%b kv=%b key=%h want 0 0 0 00",
                     lockout, load_err, key_valid, key_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vec++;
        if (kif.kin_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_ready: got %b want 1", kif.kin_ready);
        end
    endtask

    task automatic test_good_frame(input logic [7:0] k);
        send_key(k, 1'b0);
        @(negedge clk);
        vec++;
        if ({load_err, key_valid, key_out} !== {2'b00, k}) begin
            errs++;
            $display("FAIL good_check_cycle: got err=%b kv=%b key=%h want 0 0 %h",
                     load_err, key_valid, key_out, k);
        end
        @(negedge clk);
        vec++;
        if ({load_err, key_valid, key_out} !== {2'b01, k}) begin
            errs++;
            $display("FAIL good_valid: got err=%b kv=%b key=%h want 0 1 %h",
                     load_err, key_valid, key_out, k);
        end
        vec++;
        if (kif.kin_ready !== 1'b1) begin
            errs++;
            $display("FAIL good_ready: got %b want 1", kif.kin_ready);
        end
    endtask

    task automatic test_early_last;
        logic [7:0] k;
        k = 8'hA5;
        do_reset();
        for (int i = 7; i >= 3; i--) begin
            xfer_bit(k[i], i == 3);
        end
        @(negedge clk);
        vec++;
        if ({load_err, key_valid, lockout, kif.kin_ready} !== 4'b1001) begin
            errs++;
            $display("FAIL early_err: got err=%b kv=%b lk=%b rdy=%b want 1 0 0 1",
                     load_err, key_valid, lockout, kif.kin_ready);
        end
        @(negedge clk);
        vec++;
        if ({load_err, key_valid} !== 2'b00) begin
            errs++;
            $display("FAIL early_pulse: got err=%b kv=%b want 0 0", load_err, key_valid);
        end
    endtask

    task automatic test_lockout;
        logic [7:0] k;
        k = 8'hA5;
        do_reset();
        test_good_frame(k);
        for (int f = 0; f < 3; f++) begin
            bad_frame(8'h5A);
            @(negedge clk);
            vec++;
            if ({load_err, key_valid} !== 2'b10) begin
                errs++;
                $display("FAIL lock_err%0d: got err=%b kv=%b want 1 0", f, load_err, key_valid);
            end
            vec++;
            if (f < 2 && {lockout, key_out} !== {1'b0, k}) begin
                errs++;
                $display("FAIL lock_hold%0d: got lk=%b key=%h want 0 %h", f, lockout, key_out, k);
            end else if (f == 2 && {lockout, kif.kin_ready, key_out} !== 10'b10_0000_0000) begin
                errs++;
                $display("FAIL lock_enter: got lk=%b rdy=%b key=%h want 1 0 00",
                         lockout, kif.kin_ready, key_out);
            end
        end
        for (int i = 0; i < FL + 3; i++) begin
            kif.kin_valid = 1'b1;
            kif.kin_bit   = (i < 8) ? k[7-i] : ^k;
            kif.kin_last  = (i == FL - 1);
            @(negedge clk);
            vec++;
            if ({lockout, kif.kin_ready, key_valid, load_err, key_out} !== 12'h800) begin
                errs++;
                $display("FAIL lock_ignore%0d: got lk=%b rdy=%b kv=%b err=%b key=%h want 1 0 0 0 00",
                         i, lockout, kif.kin_ready, key_valid, load_err, key_out);
            end
        end
        kif.kin_valid = 1'b0;
        kif.kin_last  = 1'b0;
    endtask

    task automatic test_reload;
        logic [7:0] k;
        k = 8'h3C;
        do_reset();
        test_good_frame(8'hA5);
        for (int i = 0; i < FL; i++) begin
            xfer_bit((i < 8) ? k[7-i] : ^k, i == FL - 1);
            vec++;
            if ({key_valid, key_out} !== 9'h0A5) begin
                errs++;
                $display("FAIL reload_hold%0d: got kv=%b key=%h want 0 a5", i, key_valid, key_out);
            end
        end
        @(negedge clk);
        vec++;
        if ({key_valid, key_out} !== 9'h03C) begin
            errs++;
            $display("FAIL reload_load: got kv=%b key=%h want 0 3c", key_valid, key_out);
        end
        @(negedge clk);
        vec++;
        if ({key_valid, key_out} !== 9'h13C) begin
            errs++;
            $display("FAIL reload_valid: got kv=%b key=%h want 1 3c", key_valid, key_out);
        end
    endtask

    task automatic test_async_reset;
        logic [7:0] k;
        k = 8'h3C;
        do_reset();
        test_good_frame(8'hA5);
        for (int i = 7; i >= 4; i--) begin
            xfer_bit(k[i], 1'b0);
        end
        #2 rst_n = 1'b0;
        #1;
        vec++;
        if ({lockout, load_err, key_valid, key_out} !== 11'h0) begin
            errs++;
            $display("FAIL arst_frame: got lk=%b err=%b kv=%b key=%h want 0 0 0 00",
                     lockout, load_err, key_valid, key_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_good_frame(8'h5A);
        for (int f = 0; f < 3; f++) begin
            bad_frame(8'h81);
        end
        @(negedge clk);
        vec++;
        if (lockout !== 1'b1) begin
            errs++;
            $display("FAIL arst_prelock: got lk=%b want 1", lockout);
        end
        #2 rst_n = 1'b0;
        #1;
        vec++;
        if ({lockout, load_err, key_valid, key_out} !== 11'h0) begin
            errs++;
            $display("FAIL arst_lockout: got lk=%b err=%b kv=%b key=%h want 0 0 0 00",
                     lockout, load_err, key_valid, key_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_good_frame(8'hC3);
    endtask

    task automatic test_gaps;
        logic [7:0] k;
        logic       b;
        k = 8'hC3;
        do_reset();
        for (int j = 0; j < FL; j++) begin
            b = (j < 8) ? k[7-j] : ^k;
            for (int g = 0; g < j % 3; g++) begin
                kif.kin_valid = 1'b0;
                kif.kin_bit   = ~b;
                kif.kin_last  = 1'b1;
                @(negedge clk);
            end
            xfer_bit(b, j == FL - 1);
        end
        kif.kin_valid = 1'b1;
        kif.kin_bit   = 1'b1;
        kif.kin_last  = 1'b1;
        @(negedge clk);
        kif.kin_valid = 1'b0;
        kif.kin_last  = 1'b0;
        vec++;
        if ({load_err, key_valid, key_out} !== 10'h0C3) begin
            errs++;
            $display("FAIL gaps_load: got err=%b kv=%b key=%h want 0 0 c3",
                     load_err, key_valid, key_out);
        end
        @(negedge clk);
        vec++;
        if ({load_err, key_valid, key_out} !== 10'h1C3) begin
            errs++;
            $display("FAIL gaps_valid: got err=%b kv=%b key=%h want 0 1 c3",
                     load_err, key_valid, key_out);
        end
    endtask

    initial begin
        vec  = 0;
        errs = 0;
        test_reset();
        test_good_frame(8'hA5);
        test_early_last();
        test_lockout();
        test_reload();
        test_async_reset();
        test_gaps();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
